float_add_share_arb: RTL

- Shares one float_add_pipelined instance among req_n independent requesters.
- A round-robin arbiter grants one operand pair per cycle and registers it into the adder.
- Each issued requester index is recorded in an in-order tag FIFO, and every adder result is steered back to its originator.
- Sits between compute clients (e.g. accumulators, dot-product sequencers) and the shared pipelined FP adder.

---
 rtl/float_add_share_arb_if.sv | 31 +++
 rtl/float_add_share_arb.sv | 88 ++++++++
 2 files changed

// File: rtl/float_add_share_arb_if.sv
// float_add_share_arb_if: requester-side and adder-side buses of the shared FP adder arbiter
//   s_req_a/s_req_b/s_req_valid/s_req_ready : per-requester operand handshake (32 bits per requester)
//   m_res_data/m_res_ovf/m_res_valid        : broadcast result, one-hot valid back to the originator
//   add_in_a/add_in_b/add_in_valid          : issue port into the pipelined adder
//   add_out/add_ovf/add_out_valid           : return port from the pipelined adder
//   slave modport is taken by the arbiter; master modport by whoever drives requesters and the adder
interface float_add_share_arb_if #(
    parameter int req_n = 4
);
    logic [32*req_n-1:0] s_req_a;
    logic [32*req_n-1:0] s_req_b;
    logic [req_n-1:0] s_req_valid;
    logic [req_n-1:0] s_req_ready;
    logic [31:0] m_res_data;
    logic m_res_ovf;
    logic [req_n-1:0] m_res_valid;
    logic [31:0] add_in_a;
    logic [31:0] add_in_b;
    logic add_in_valid;
    logic [31:0] add_out;
    logic add_ovf;
    logic add_out_valid;
    modport slave (
        input s_req_a, s_req_b, s_req_valid, add_out, add_ovf, add_out_valid,
        output s_req_ready, m_res_data, m_res_ovf, m_res_valid, add_in_a, add_in_b, add_in_valid
    );
    modport master (
        output s_req_a, s_req_b, s_req_valid, add_out, add_ovf, add_out_valid,
        input s_req_ready, m_res_data, m_res_ovf, m_res_valid, add_in_a, add_in_b, add_in_valid
    );
endinterface

// File: rtl/float_add_share_arb.sv
// float_add_share_arb: round-robin sharing of one pipelined FP adder among req_n requesters
//   clk, rst_n    : clock, asynchronous active-low reset (the adder must share this rst_n)
//   arb_en        : 1 allows new grants; in-flight results always return
//   bus (slave)   : requester handshake, result broadcast, adder issue/return ports
//   inflight_cnt  : operations issued and not yet returned
//   err_orphan    : sticky, a result arrived while nothing was in flight
module float_add_share_arb #(
    parameter int req_n = 4,
    parameter int tag_fifo_depth = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic arb_en,
    float_add_share_arb_if.slave bus,
    output logic [$clog2(tag_fifo_depth):0] inflight_cnt,
    output logic err_orphan
);
    localparam int tw = $clog2(req_n);
    localparam int pw = $clog2(tag_fifo_depth);

    logic [tw-1:0] last_grant;
    logic [tw-1:0] grant_idx;
    logic [tw-1:0] tags [tag_fifo_depth];
    logic [pw-1:0] wr_ptr;
    logic [pw-1:0] rd_ptr;
    logic can_grant;
    logic xfer;
    logic pop;
    logic orphan;

    // Full check ignores a same-cycle return so ready never depends on add_out_valid.
    assign can_grant = arb_en && (inflight_cnt != (pw+1)'(tag_fifo_depth));
    assign pop = bus.add_out_valid && (inflight_cnt != '0);
    assign orphan = bus.add_out_valid && (inflight_cnt == '0);
    assign bus.s_req_ready = xfer ? (req_n'(1) << grant_idx) : '0;

    // Scan from farthest to nearest offset so the requester closest after last_grant wins.
    always_comb begin
        int j;
        j = 0;
        grant_idx = last_grant;
        xfer = 1'b0;
        for (int k = req_n; k >= 1; k--) begin
            j = (int'(last_grant) + k) % req_n;
            if (can_grant && bus.s_req_valid[j]) begin
                grant_idx = tw'(j);
                xfer = 1'b1;
            end
        end
    end

    // Tag storage needs no reset: only entries between rd_ptr and wr_ptr are ever read.
    always_ff @(posedge clk) begin
        if (xfer) tags[wr_ptr] <= grant_idx;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= tw'(req_n - 1);
            wr_ptr <= '0;
            rd_ptr <= '0;
            inflight_cnt <= '0;
            err_orphan <= 1'b0;
            bus.add_in_a <= '0;
            bus.add_in_b <= '0;
            bus.add_in_valid <= 1'b0;
            bus.m_res_data <= '0;
            bus.m_res_ovf <= 1'b0;
            bus.m_res_valid <= '0;
        end else begin
            bus.add_in_valid <= xfer;
            if (xfer) begin
                last_grant <= grant_idx;
                bus.add_in_a <= bus.s_req_a[32*grant_idx +: 32];
                bus.add_in_b <= bus.s_req_b[32*grant_idx +: 32];
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                bus.m_res_data <= bus.add_out;
                bus.m_res_ovf <= bus.add_ovf;
            end
            bus.m_res_valid <= pop ? (req_n'(1) << tags[rd_ptr]) : '0;
            inflight_cnt <= inflight_cnt + (pw+1)'(xfer) - (pw+1)'(pop);
            if (orphan) err_orphan <= 1'b1;
        end
    end
endmodule
